key_expand_seq: RTL and testbench



---
 rtl/aes_pkg.sv | 59 +++++
 rtl/sub_word.sv | 15 +
 rtl/key_expand_seq.sv | 159 +++++++++++++++
 tb/tb_key_expand_seq.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions for the key-schedule sequencer and the round datapath.
//   ks_state_e  : key-schedule sequencer states
//   RCON_INIT   : first round constant
//   XTIME_POLY  : GF(2^8) reduction constant used by xtime
//   nr_of(nk)   : round count for a key of nk 32-bit words
//   xtime/gf_mul/sbox : GF(2^8) helpers; sbox is computed, not tabulated
package aes_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StGen     = 2'd1,
    StPresent = 2'd2,
    StFin     = 2'd3
  } ks_state_e;

  localparam logic [7:0] RCON_INIT  = 8'h01;
  localparam logic [7:0] XTIME_POLY = 8'h1B;

  function automatic int unsigned nr_of(input int unsigned nk);
    return nk + 6;
  endfunction

  // Multiply by x modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? XTIME_POLY : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // S-box = affine(x^254). x^254 is the multiplicative inverse (and maps 0 to 0),
  // built from a short square-and-multiply chain: 254 = 240 + 12 + 2.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, inv;
    x2   = gf_mul(x, x);
    x3   = gf_mul(x2, x);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x15  = gf_mul(x12, x3);
    x30  = gf_mul(x15, x15);
    x60  = gf_mul(x30, x30);
    x120 = gf_mul(x60, x60);
    x240 = gf_mul(x120, x120);
    x252 = gf_mul(x240, x12);
    inv  = gf_mul(x252, x2);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

endpackage

// File: rtl/sub_word.sv
// SubWord: applies the AES S-box to each byte of a 32-bit word. Purely
// combinational; shared with the round datapath so both use one S-box design.
//   i_word : input word
//   o_word : byte-wise substituted word
module sub_word
  import aes_pkg::*;
(
  input  logic [31:0] i_word,
  output logic [31:0] o_word
);

  assign o_word = {sbox(i_word[31:24]), sbox(i_word[23:16]),
                   sbox(i_word[15:8]),  sbox(i_word[7:0])};

endmodule

// File: rtl/key_expand_seq.sv
// Iterative AES key-schedule sequencer. Generates one expanded word per cycle,
// packs four words into a round key and offers it on a valid/ready handshake.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_start        : start request, sampled only while idle
//   i_key          : cipher key, left-aligned (top 32*NK bits used)
//   o_busy         : high while generating/presenting round keys
//   o_rk, o_rk_idx : round key r and its index r
//   o_rk_valid     : round key valid
//   i_rk_ready     : consumer ready; transfer = o_rk_valid && i_rk_ready
//   o_done         : one-cycle pulse after the final transfer
module key_expand_seq
  import aes_pkg::*;
#(
  parameter int unsigned NK = 4
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_start,
  input  logic [255:0]   i_key,
  output logic           o_busy,
  output logic [127:0]   o_rk,
  output logic [3:0]     o_rk_idx,
  output logic           o_rk_valid,
  input  logic           i_rk_ready,
  output logic           o_done
);

  localparam int unsigned NR   = nr_of(NK);
  localparam logic [5:0]  NK_W = 6'(NK);
  localparam logic [3:0]  NR_W = 4'(NR);

  if (!(NK == 4 || NK == 6 || NK == 8)) begin : g_bad_nk
    $error("key_expand_seq: NK must be 4, 6 or 8");
  end

  // Key bits below the used words are intentionally ignored.
  if (NK < 8) begin : g_unused_key
    logic unused_key_bits;
    assign unused_key_bits = ^i_key[255-32*NK:0];
  end

  ks_state_e   state_q, state_d;
  logic [5:0]  i_q, i_d;
  logic [7:0]  rcon_q, rcon_d;
  logic [3:0]  r_q, r_d;
  // win_q[0] is the oldest word w[i-NK], win_q[NK-1] the newest w[i-1].
  logic [31:0] win_q [NK];
  logic [31:0] win_d [NK];
  logic [31:0] acc_q [4];
  logic [31:0] acc_d [4];

  logic [5:0]  i_mod;
  logic        is_key_word;
  logic        is_rot;
  logic        is_sub;
  logic [31:0] prev_word;
  logic [31:0] sw_in;
  logic [31:0] sw_out;
  logic [31:0] new_word;

  assign i_mod       = i_q % NK_W;
  assign is_key_word = (i_q < NK_W);
  assign is_rot      = !is_key_word && (i_mod == 6'd0);
  assign is_sub      = (NK == 8) && !is_key_word && (i_mod == 6'd4);
  assign prev_word   = win_q[NK-1];

  // Single S-box instance: RotWord is applied in front of it only on the Rcon step.
  assign sw_in = is_rot ? {prev_word[23:0], prev_word[31:24]} : prev_word;

  sub_word u_sub_word (
    .i_word (sw_in),
    .o_word (sw_out)
  );

  // While i < NK the window is loaded with the key itself, so the oldest entry is
  // exactly key word i; rotating it back in leaves w[0..NK-1] in place for i = NK.
  always_comb begin
    if (is_key_word) begin
      new_word = win_q[0];
    end else if (is_rot) begin
      new_word = win_q[0] ^ sw_out ^ {rcon_q, 24'h000000};
    end else if (is_sub) begin
      new_word = win_q[0] ^ sw_out;
    end else begin
      new_word = win_q[0] ^ prev_word;
    end
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    rcon_d  = rcon_q;
    r_d     = r_q;
    for (int unsigned k = 0; k < NK; k++) win_d[k] = win_q[k];
    for (int unsigned k = 0; k < 4; k++)  acc_d[k] = acc_q[k];

    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          for (int unsigned k = 0; k < NK; k++) win_d[k] = i_key[255-32*k -: 32];
          i_d     = 6'd0;
          rcon_d  = RCON_INIT;
          r_d     = 4'd0;
          state_d = StGen;
        end
      end
      StGen: begin
        for (int unsigned k = 0; k + 1 < NK; k++) win_d[k] = win_q[k+1];
        win_d[NK-1]      = new_word;
        acc_d[i_q[1:0]]  = new_word;
        i_d              = i_q + 6'd1;
        if (is_rot) rcon_d = xtime(rcon_q);
        if (i_q[1:0] == 2'd3) state_d = StPresent;
      end
      StPresent: begin
        // Everything above holds while the consumer stalls.
        if (i_rk_ready) begin
          if (r_q == NR_W) begin
            state_d = StFin;
          end else begin
            r_d     = r_q + 4'd1;
            state_d = StGen;
          end
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      i_q     <= 6'd0;
      rcon_q  <= RCON_INIT;
      r_q     <= 4'd0;
      for (int unsigned k = 0; k < NK; k++) win_q[k] <= 32'h0;
      for (int unsigned k = 0; k < 4; k++)  acc_q[k] <= 32'h0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      rcon_q  <= rcon_d;
      r_q     <= r_d;
      for (int unsigned k = 0; k < NK; k++) win_q[k] <= win_d[k];
      for (int unsigned k = 0; k < 4; k++)  acc_q[k] <= acc_d[k];
    end
  end

  assign o_busy     = (state_q == StGen) || (state_q == StPresent);
  assign o_rk_valid = (state_q == StPresent);
  assign o_done     = (state_q == StFin);
  assign o_rk       = {acc_q[0], acc_q[1], acc_q[2], acc_q[3]};
  assign o_rk_idx   = r_q;

endmodule

// File: tb/tb_key_expand_seq.sv
// Bench for key_expand_seq: three instances (NK = 4, 6, 8) checked against a
// FIPS-197 style key-expansion model through per-instance scoreboards.
module tb_key_expand_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         start [3];
  logic [255:0] key   [3];
  logic         ready [3];
  logic         busy  [3];
  logic [127:0] rk    [3];
  logic [3:0]   idx   [3];
  logic         valid [3];
  logic         done  [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    key_expand_seq #(.NK(4 + 2 * g)) u_dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_start    (start[g]),
      .i_key      (key[g]),
      .o_busy     (busy[g]),
      .o_rk       (rk[g]),
      .o_rk_idx   (idx[g]),
      .o_rk_valid (valid[g]),
      .i_rk_ready (ready[g]),
      .o_done     (done[g])
    );
  end

  typedef struct {
    logic [3:0]   idx;
    logic [127:0] rk;
  } exp_t;

  exp_t         expq [3][$];
  logic [127:0] got_rk [3][15];
  int           xfer_cnt [3];
  int           mode [3];      // 0: ready tied high, 1: random 0-7 cycle stall per key
  int           pending [3];
  int           stall [3];
  int           checks = 0;
  int           errors = 0;
  logic [7:0]   sbox_t [256];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    while (b != 8'h00) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  // S-box table: inverse found by exhaustive search, then the bitwise affine map.
  task automatic build_sbox();
    logic [7:0] inv, s, c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int b = 0; b < 8; b++)
        s[b] = inv[b] ^ inv[(b+4)%8] ^ inv[(b+5)%8] ^ inv[(b+6)%8] ^ inv[(b+7)%8] ^ c[b];
      sbox_t[x] = s;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] x);
    return {sbox_t[x[31:24]], sbox_t[x[23:16]], sbox_t[x[15:8]], sbox_t[x[7:0]]};
  endfunction

  task automatic push_model(input int g, input logic [255:0] k);
    int nk = 4 + 2 * g;
    int nw = 4 * (nk + 7);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    exp_t e;
    for (int i = 0; i < nw; i++) begin
      if (i < nk) begin
        w[i] = k[255 - 32 * i -: 32];
      end else begin
        t = w[i-1];
        if (i % nk == 0) begin
          t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
          rc = gmul(rc, 8'h02);
        end else if (nk == 8 && i % 8 == 4) begin
          t = subw(t);
        end
        w[i] = w[i-nk] ^ t;
      end
    end
    for (int r = 0; r <= nk + 6; r++) begin
      e.idx = 4'(r);
      e.rk  = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      expq[g].push_back(e);
    end
  endtask

  // Monitor: every presented key is compared with the scoreboard head (so a stalled
  // key must stay equal to it); the head is popped on transfer.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int g = 0; g < 3; g++) begin
        if (valid[g]) begin
          if (expq[g].size() == 0) begin
            chk($sformatf("unexpected key nk%0d", 4 + 2 * g), 128'(idx[g]), 128'hdead);
          end else begin
            chk($sformatf("rk nk%0d idx%0d", 4 + 2 * g, expq[g][0].idx), rk[g], expq[g][0].rk);
            chk($sformatf("idx nk%0d", 4 + 2 * g), 128'(idx[g]), 128'(expq[g][0].idx));
            if (ready[g]) begin
              got_rk[g][idx[g]] = rk[g];
              xfer_cnt[g]++;
              void'(expq[g].pop_front());
            end
          end
        end
      end
    end
  end

  // Ready driver; outside PRESENT the random mode toggles ready to show it is ignored.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int g = 0; g < 3; g++) begin
        if (mode[g] == 0) begin
          ready[g] = 1'b1;
        end else if (!valid[g]) begin
          pending[g] = 0;
          ready[g]   = 1'($urandom_range(0, 1));
        end else begin
          if (pending[g] == 0) begin
            pending[g] = 1;
            stall[g]   = $urandom_range(0, 7);
          end
          if (stall[g] == 0) begin
            ready[g] = 1'b1;
          end else begin
            ready[g] = 1'b0;
            stall[g]--;
          end
        end
      end
    end
  end

  function automatic logic [255:0] rand_key();
    logic [255:0] k;
    for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom;
    return k;
  endfunction

  task automatic run_key(input int g, input logic [255:0] k, input bit noise);
    int n = 0;
    int nk = 4 + 2 * g;
    push_model(g, k);
    xfer_cnt[g] = 0;
    key[g]   = k;
    start[g] = 1'b1;
    @(posedge clk);
    #1;
    start[g] = 1'b0;
    chk("busy after start", 128'(busy[g]), 128'h1);
    while (!done[g] && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
      if (noise) begin
        start[g] = (n < 40) ? 1'($urandom_range(0, 1)) : 1'b0;
        key[g]   = rand_key();
      end
    end
    if (n >= 3000) chk("done timeout", 128'(n), 128'h0);
    if (mode[g] == 0) chk($sformatf("done latency nk%0d", nk), 128'(n), 128'(5 * (nk + 7)));
    chk("busy low at done", 128'(busy[g]), 128'h0);
    @(posedge clk);
    #1;
    chk("done single pulse", 128'(done[g]), 128'h0);
    chk($sformatf("transfers nk%0d", nk), 128'(xfer_cnt[g]), 128'(nk + 7));
    chk("scoreboard drained", 128'(expq[g].size()), 128'h0);
    start[g] = 1'b0;
  endtask

  localparam logic [127:0] K128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [191:0] K192 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [255:0] K256 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  task automatic kat128();
    chk("aes128 r0", got_rk[0][0], K128);
    chk("aes128 r1", got_rk[0][1], 128'ha0fafe1788542cb123a339392a6c7605);
    chk("aes128 r10", got_rk[0][10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
  endtask

  initial begin
    int n;
    logic [255:0] k;
    for (int g = 0; g < 3; g++) begin
      start[g] = 1'b0;
      key[g]   = '0;
      ready[g] = 1'b1;
      mode[g]  = 0;
      pending[g] = 0;
      stall[g] = 0;
      xfer_cnt[g] = 0;
    end
    build_sbox();
    #2;
    for (int g = 0; g < 3; g++) begin
      chk("reset outputs", {rk[g][127:5], busy[g], valid[g], done[g], idx[g] != 4'd0},
          128'h0);
    end
    #10;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Known-answer runs, ready tied high.
    run_key(0, {K128, 128'(rand_key())}, 1'b0);
    kat128();
    run_key(1, {K192, 64'(rand_key())}, 1'b0);
    chk("aes192 r1", got_rk[1][1], 128'h62f8ead2522c6b7bfe0c91f72402f5a5);
    run_key(2, K256, 1'b0);
    chk("aes256 r2", got_rk[2][2], 128'h9ba354118e6925afa51a8b5f2067fcde);
    chk("aes256 r14", got_rk[2][14], 128'hfe4890d1e6188d0b046df344706c631e);

    // Random back-pressure.
    mode[0] = 1;
    for (int g = 0; g < 3; g++) got_rk[0][g] = '0;
    run_key(0, {K128, 128'h0}, 1'b0);
    kat128();
    mode[0] = 0;

    // Start pulses and key changes while busy are ignored.
    run_key(0, {K128, 128'h0}, 1'b1);
    kat128();

    // Reset while key 5 is presented, then restart.
    push_model(0, {K128, 128'h0});
    key[0]   = {K128, 128'h0};
    start[0] = 1'b1;
    @(posedge clk);
    #1;
    start[0] = 1'b0;
    n = 0;
    while (!(valid[0] && idx[0] == 4'd5) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 200) chk("wait idx5 timeout", 128'(n), 128'h0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid reset rk", rk[0], 128'h0);
    chk("mid reset ctl", {124'h0, busy[0], valid[0], done[0], idx[0] != 4'd0}, 128'h0);
    expq[0].delete();
    @(posedge clk);
    #1;
    chk("held reset done", 128'(done[0]), 128'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_key(0, {K128, 128'h0}, 1'b0);
    kat128();

    // Random keys on every width, random ready mode.
    for (int it = 0; it < 3; it++) begin
      for (int g = 0; g < 3; g++) begin
        mode[g] = $urandom_range(0, 1);
        k = rand_key();
        run_key(g, k, 1'b0);
        chk($sformatf("r0 equals key nk%0d", 4 + 2 * g), got_rk[g][0], k[255:128]);
        mode[g] = 0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
